// File: rtl/mem_access_pkg.sv
// Shared constants for the RV32I memory-access stage: opcodes, load funct3 codes
// and the request FSM encoding.
package mem_access_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// Bundle of the ALU-stage input bus, the data-memory port, stall and forwarding
// outputs of the memory-access stage.
interface mem_access_if #(
  parameter int ADDR_W = 32
);

  logic [31:0]       a_pc;
  logic [31:0]       a_inst;
  logic              a_valid;
  logic [4:0]        a_reg_d;
  logic [31:0]       a_reg_d_v;
  logic [31:0]       a_load_addr;
  logic [31:0]       a_store_addr;
  logic [3:0]        a_store_strb;
  logic [31:0]       a_store_data;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_err;

  logic              stall;
  logic              fwd_m_valid;
  logic [4:0]        fwd_m_reg_d;
  logic [31:0]       fwd_m_reg_d_v;
  logic              fwd_w_valid;
  logic [4:0]        fwd_w_reg_d;
  logic [31:0]       fwd_w_reg_d_v;

  // The stage itself masters the data-memory port.
  modport master (
    input  a_pc, a_inst, a_valid, a_reg_d, a_reg_d_v, a_load_addr, a_store_addr,
           a_store_strb, a_store_data, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_err, stall,
           fwd_m_valid, fwd_m_reg_d, fwd_m_reg_d_v,
           fwd_w_valid, fwd_w_reg_d, fwd_w_reg_d_v
  );

  modport slave (
    output a_pc, a_inst, a_valid, a_reg_d, a_reg_d_v, a_load_addr, a_store_addr,
           a_store_strb, a_store_data, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_err, stall,
           fwd_m_valid, fwd_m_reg_d, fwd_m_reg_d_v,
           fwd_w_valid, fwd_w_reg_d, fwd_w_reg_d_v
  );

endinterface

// File: rtl/mem_access_load_align.sv
// Combinational load extraction: selects the byte/half/word lane of the read
// word and sign- or zero-extends it according to funct3.
module mem_access_load_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension; unknown funct3 yields zero.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    value  = 32'h0000_0000;
    case (byte_off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (byte_off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_LB:   value = {{24{byte_s[7]}}, byte_s};
      F3_LH:   value = {{16{half_s[15]}}, half_s};
      F3_LW:   value = rdata;
      F3_LBU:  value = {24'h000000, byte_s};
      F3_LHU:  value = {16'h0000, half_s};
      default: value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access (M) stage plus writeback (W) register: issues loads/stores
// on a req/ack port, stalls upstream until completion, drives M/W forwarding.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.master bus
);

  localparam logic        TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  logic        m_valid_r;
  logic [31:0] m_inst_r;
  logic [4:0]  m_reg_d_r;
  logic [31:0] m_reg_d_v_r;
  logic [31:0] m_load_addr_r;
  logic [31:0] m_store_addr_r;
  logic [3:0]  m_strb_r;
  logic [31:0] m_data_r;

  mem_state_t  state_r;
  logic [31:0] cnt_r;
  logic        mem_err_r;

  logic        w_valid_r;
  logic [4:0]  w_reg_d_r;
  logic [31:0] w_val_r;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        is_ld_s;
  logic        is_st_s;
  logic        mem_op_s;
  logic        ack_hit_s;
  logic        timeout_s;
  logic        done_s;
  logic        stall_s;
  logic [31:0] ld_value_s;
  logic [31:0] m_result_s;
  logic [31:0] addr_full_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s;
  logic        unused_s;

  assign opcode_s = m_inst_r[6:0];
  assign funct3_s = m_inst_r[14:12];
  assign is_ld_s  = m_valid_r && (opcode_s == OPC_LOAD);
  assign is_st_s  = m_valid_r && (opcode_s == OPC_STORE);
  assign mem_op_s = is_ld_s || is_st_s;

  // ACK is only honoured once the request has been seen for a full cycle (ACCESS).
  assign ack_hit_s = (state_r == ST_ACCESS) && bus.mem_ack;
  assign timeout_s = TO_EN && mem_op_s && !ack_hit_s && (cnt_r == TO_LAST);
  assign done_s    = ack_hit_s || timeout_s;
  assign stall_s   = mem_op_s && !done_s;

  mem_access_load_align u_load_align (
    .funct3   (funct3_s),
    .byte_off (m_load_addr_r[1:0]),
    .rdata    (bus.mem_rdata),
    .value    (ld_value_s)
  );

  // Result carried by the M instruction: load data on ACK, zero on abort.
  always_comb begin
    m_result_s = m_reg_d_v_r;
    if (is_ld_s) begin
      if (ack_hit_s) begin
        m_result_s = ld_value_s;
      end else begin
        m_result_s = 32'h0000_0000;
      end
    end else begin
      m_result_s = m_reg_d_v_r;
    end
  end

  // Memory-port address/strobe/data mux; everything idles at zero.
  always_comb begin
    addr_full_s = 32'h0000_0000;
    wstrb_s     = 4'h0;
    wdata_s     = 32'h0000_0000;
    if (is_st_s) begin
      addr_full_s = m_store_addr_r;
      wstrb_s     = m_strb_r;
      wdata_s     = m_data_r;
    end else if (is_ld_s) begin
      addr_full_s = m_load_addr_r;
    end else begin
      addr_full_s = 32'h0000_0000;
    end
  end

  // M stage register: follows the ALU stage unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r      <= 1'b0;
      m_inst_r       <= 32'h0000_0000;
      m_reg_d_r      <= 5'd0;
      m_reg_d_v_r    <= 32'h0000_0000;
      m_load_addr_r  <= 32'h0000_0000;
      m_store_addr_r <= 32'h0000_0000;
      m_strb_r       <= 4'h0;
      m_data_r       <= 32'h0000_0000;
    end else if (!stall_s) begin
      m_valid_r      <= bus.a_valid;
      m_inst_r       <= bus.a_inst;
      m_reg_d_r      <= bus.a_reg_d;
      m_reg_d_v_r    <= bus.a_reg_d_v;
      m_load_addr_r  <= bus.a_load_addr;
      m_store_addr_r <= bus.a_store_addr;
      m_strb_r       <= bus.a_store_strb;
      m_data_r       <= bus.a_store_data;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  // Request FSM with request-age counter and registered abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 32'd0;
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= timeout_s;
      case (state_r)
        ST_IDLE: begin
          if (mem_op_s && !done_s) begin
            state_r <= ST_ACCESS;
            cnt_r   <= 32'd1;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
          end
        end
        ST_ACCESS: begin
          if (done_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 32'd0;
          end else begin
            state_r <= ST_ACCESS;
            cnt_r   <= cnt_r + 32'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 32'd0;
        end
      endcase
    end
  end

  // Writeback register; stall cycles and stores become bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid_r <= 1'b0;
      w_reg_d_r <= 5'd0;
      w_val_r   <= 32'h0000_0000;
    end else begin
      w_valid_r <= m_valid_r && !stall_s && !is_st_s && (m_reg_d_r != 5'd0);
      w_reg_d_r <= m_reg_d_r;
      w_val_r   <= m_result_s;
    end
  end

  assign bus.mem_req       = mem_op_s;
  assign bus.mem_we        = is_st_s;
  assign bus.mem_addr      = {addr_full_s[ADDR_W-1:2], 2'b00};
  assign bus.mem_wstrb     = wstrb_s;
  assign bus.mem_wdata     = wdata_s;
  assign bus.mem_err       = mem_err_r;
  assign bus.stall         = stall_s;
  assign bus.fwd_m_valid   = m_valid_r && (m_reg_d_r != 5'd0) && !is_st_s && (!is_ld_s || done_s);
  assign bus.fwd_m_reg_d   = m_reg_d_r;
  assign bus.fwd_m_reg_d_v = m_result_s;
  assign bus.fwd_w_valid   = w_valid_r;
  assign bus.fwd_w_reg_d   = w_reg_d_r;
  assign bus.fwd_w_reg_d_v = w_val_r;

  assign unused_s = ^{bus.a_pc, m_inst_r, m_store_addr_r[1:0], addr_full_s};

endmodule
